if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 86 ++++++++
 tb/tb_if_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: walks a PC through a combinational instruction ROM and
// buffers {pc, inst} pairs in a small FIFO for the decode stage.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        id_ready_i
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: the head entry moves downstream on a cycle where id_valid_o and
  // id_ready_i are both high and the unit is neither stalled nor redirecting.

  logic [31:0]      pc;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      pc_mem   [QUEUE_DEPTH];
  logic [31:0]      inst_mem [QUEUE_DEPTH];

  logic full;
  logic pop;
  logic push;

  // Chip enable follows reset directly so the first fetch lands in the first
  // cycle after reset is released.
  assign rom_ce_o   = rst;
  assign rom_addr_o = pc;

  assign full = (count == CNT_W'(QUEUE_DEPTH));
  assign pop  = id_valid_o && id_ready_i && !stall_i && !branch_flag_i;
  assign push = rom_ce_o && !stall_i && !branch_flag_i && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (branch_flag_i) begin
      pc    <= {branch_target_i[31:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
        pc   <= pc + 32'd4;
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage carries no reset; only the pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem[tail]   <= pc;
      inst_mem[tail] <= rom_inst_i;
    end
  end

  assign id_valid_o = (count != '0);
  assign id_pc_o    = id_valid_o ? pc_mem[head]   : 32'h0;
  assign id_inst_o  = id_valid_o ? inst_mem[head] : 32'h0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a queue-based reference model tracks the PC and the
// buffered {pc, inst} pairs; a second instance covers the PC wrap at 2^32.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h00000000;
  localparam int          DEPTH  = 2;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i;
  logic [31:0] key;

  logic        rst2;
  logic        rom_ce2;
  logic [31:0] rom_addr2;
  logic [31:0] rom_inst2;
  logic        id_valid2;
  logic [31:0] id_pc2;
  logic [31:0] id_inst2;

  int n_checks;
  int n_fail;

  logic [63:0] exp_q[$];
  logic [31:0] mpc;

  if_fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o),
    .rom_inst_i(rom_inst_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .id_ready_i(id_ready_i)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFFFFF8), .QUEUE_DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst2), .stall_i(1'b0), .branch_flag_i(1'b0),
    .branch_target_i(32'h0), .rom_ce_o(rom_ce2), .rom_addr_o(rom_addr2),
    .rom_inst_i(rom_inst2), .id_valid_o(id_valid2), .id_pc_o(id_pc2),
    .id_inst_o(id_inst2), .id_ready_i(1'b1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word n holds n, optionally scrambled by a bench-chosen key.
  function automatic logic [31:0] rom_word(input logic [31:0] addr, input logic [31:0] k);
    return (addr >> 2) ^ k;
  endfunction

  assign rom_inst_i = rom_word(rom_addr_o, key);
  assign rom_inst2  = rom_word(rom_addr2, 32'h0);

  // One clock cycle: drive inputs, compare outputs to the model, advance model.
  task automatic step(input logic r, input logic s, input logic b, input logic rdy,
                      input logic [31:0] tgt, input bit chk);
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    bit          do_pop;
    bit          do_push;
    logic [63:0] ent;
    rst = r; stall_i = s; branch_flag_i = b; id_ready_i = rdy; branch_target_i = tgt;
    #1;
    if (chk) begin
      e_valid = (exp_q.size() != 0);
      e_pc    = e_valid ? exp_q[0][63:32] : 32'h0;
      e_inst  = e_valid ? exp_q[0][31:0]  : 32'h0;
      n_checks += 5;
      if (rom_ce_o !== r) begin
        n_fail++; $display("FAIL rom_ce: got %b expected %b", rom_ce_o, r);
      end
      if (rom_addr_o !== mpc) begin
        n_fail++; $display("FAIL rom_addr: got %h expected %h", rom_addr_o, mpc);
      end
      if (id_valid_o !== e_valid) begin
        n_fail++; $display("FAIL id_valid: got %b expected %b", id_valid_o, e_valid);
      end
      if (id_pc_o !== e_pc) begin
        n_fail++; $display("FAIL id_pc: got %h expected %h", id_pc_o, e_pc);
      end
      if (id_inst_o !== e_inst) begin
        n_fail++; $display("FAIL id_inst: got %h expected %h", id_inst_o, e_inst);
      end
    end
    if (!r) begin
      exp_q.delete();
      mpc = RST_PC;
    end else if (b) begin
      exp_q.delete();
      mpc = {tgt[31:2], 2'b00};
    end else if (!s) begin
      do_pop  = (exp_q.size() != 0) && rdy;
      do_push = (exp_q.size() < DEPTH) || do_pop;
      ent     = {mpc, rom_word(mpc, key)};
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(ent);
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h1234, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
  endtask

  task automatic test_backpressure();
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (rom_addr_o !== 32'h8) begin
      n_fail++; $display("FAIL backpressure_pc_hold: got %h expected %h", rom_addr_o, 32'h8);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
  endtask

  task automatic test_branch();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h00000043, 1'b1);
    n_checks += 2;
    if (id_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL branch_flush: got %b expected %b", id_valid_o, 1'b0);
    end
    if (rom_addr_o !== 32'h40) begin
      n_fail++; $display("FAIL branch_pc: got %h expected %h", rom_addr_o, 32'h40);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    n_checks++;
    if (id_pc_o !== 32'h40) begin
      n_fail++; $display("FAIL branch_head: got %h expected %h", id_pc_o, 32'h40);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
  endtask

  task automatic test_stall();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h00000100, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h00000200, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    logic r, s, b, rdy;
    for (int i = 0; i < 300; i++) begin
      key = $urandom;
      r   = ($urandom_range(0, 49) != 0);
      s   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(r, s, b, rdy, $urandom, 1'b1);
    end
    key = 32'h0;
  endtask

  task automatic test_reset_pc_wrap();
    logic [31:0] exp_pc;
    rst2 = 1'b0;
    @(posedge clk);
    #1;
    rst2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'hFFFFFFF8 + 32'(4 * k);
      #1;
      n_checks++;
      if (rom_addr2 !== exp_pc) begin
        n_fail++; $display("FAIL wrap_rom_addr: got %h expected %h", rom_addr2, exp_pc);
      end
      @(posedge clk);
      #1;
      n_checks += 3;
      if (id_valid2 !== 1'b1) begin
        n_fail++; $display("FAIL wrap_valid: got %b expected %b", id_valid2, 1'b1);
      end
      if (id_pc2 !== exp_pc) begin
        n_fail++; $display("FAIL wrap_id_pc: got %h expected %h", id_pc2, exp_pc);
      end
      if (id_inst2 !== (exp_pc >> 2)) begin
        n_fail++; $display("FAIL wrap_id_inst: got %h expected %h", id_inst2, exp_pc >> 2);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    key      = 32'h0;
    mpc      = RST_PC;
    rst      = 1'b0;
    rst2     = 1'b0;
    stall_i  = 1'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;
    id_ready_i      = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_stall();
    test_reset_mid();
    test_random();
    test_reset_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
